// File: rtl/gpio_guard.sv
// Guards CPU GPIO writes to the LEDs: only changes inside an SVC window reach the pins.
// Changes outside a window are blocked, counted and latched as an alarm; all outputs registered.
module gpio_guard #(
  parameter int WINDOW_CYCLES = 8,
  parameter logic [3:0] LED_RESET = 4'b1111,
  parameter int COUNT_WIDTH = 8,
  parameter int LOCK_THRESHOLD = 4
) (
  input  logic                   Clock,
  input  logic                   reset,
  input  logic [3:0]             cpu_gpio,
  input  logic                   svc_entry,
  input  logic                   ret_exec,
  input  logic                   clear_alarm,
  output logic [3:0]             led_out,
  output logic                   alarm,
  output logic                   locked,
  output logic                   window_active,
  output logic [COUNT_WIDTH-1:0] violation_count
);

  typedef enum logic [1:0] {IDLE, WINDOW, ALARM} state_t;

  localparam logic [7:0] WIN_LOAD = 8'(WINDOW_CYCLES);

  state_t                 state, state_n;
  logic [7:0]             win_cnt, win_cnt_n;
  logic [3:0]             gpio_q;
  logic [3:0]             led_n;
  logic                   alarm_n, locked_n, violation;
  logic [COUNT_WIDTH-1:0] count_n;
  logic                   change;

  assign change = (cpu_gpio != gpio_q);

  always_comb begin
    state_n   = state;
    win_cnt_n = win_cnt;
    led_n     = led_out;
    alarm_n   = alarm;
    locked_n  = locked;
    count_n   = violation_count;
    violation = 1'b0;
    case (state)
      IDLE: begin
        // A change beats a simultaneous SVC: the window never opens.
        if (change) begin
          violation = 1'b1;
          state_n   = ALARM;
        end else if (svc_entry) begin
          state_n   = WINDOW;
          win_cnt_n = WIN_LOAD;
        end
      end
      WINDOW: begin
        if (change) led_n = cpu_gpio;
        win_cnt_n = svc_entry ? WIN_LOAD : win_cnt - 8'd1;
        if (ret_exec || (win_cnt == 8'd1 && !svc_entry)) state_n = IDLE;
      end
      ALARM: begin
        if (change) begin
          violation = 1'b1;
        end else if (clear_alarm && !locked) begin
          state_n = IDLE;
          alarm_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (violation) begin
      if (!(&violation_count)) count_n = violation_count + COUNT_WIDTH'(1);
      alarm_n = 1'b1;
      if (32'(count_n) >= LOCK_THRESHOLD) locked_n = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      win_cnt         <= 8'd0;
      gpio_q          <= LED_RESET;
      led_out         <= LED_RESET;
      alarm           <= 1'b0;
      locked          <= 1'b0;
      window_active   <= 1'b0;
      violation_count <= '0;
    end else begin
      state           <= state_n;
      win_cnt         <= win_cnt_n;
      gpio_q          <= cpu_gpio;
      led_out         <= led_n;
      alarm           <= alarm_n;
      locked          <= locked_n;
      window_active   <= (state_n == WINDOW);
      violation_count <= count_n;
    end
  end

endmodule

// File: tb/tb_gpio_guard.sv
// Bench for gpio_guard: directed test-plan sequences plus random traffic, all checked
// every cycle against a deadline-based reference model.
module tb_gpio_guard;
  localparam int W = 8;
  localparam int THRESH = 4;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cpu_gpio = 4'hF;
  logic       svc_entry = 1'b0, ret_exec = 1'b0, clear_alarm = 1'b0;
  logic [3:0] led_out;
  logic       alarm, locked, window_active;
  logic [7:0] violation_count;

  gpio_guard dut (
    .Clock(Clock), .reset(reset), .cpu_gpio(cpu_gpio), .svc_entry(svc_entry),
    .ret_exec(ret_exec), .clear_alarm(clear_alarm), .led_out(led_out), .alarm(alarm),
    .locked(locked), .window_active(window_active), .violation_count(violation_count)
  );

  always #5 Clock = ~Clock;

  int total = 0, bad = 0;

  // Reference: a window is open up to and including an absolute deadline cycle.
  int   cyc = 0, deadline = 0, m_count = 0;
  bit   m_win = 0, m_alarm = 0, m_locked = 0;
  logic [3:0] m_led = 4'hF, m_prev = 4'hF;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("led", led_out, m_led);
    chk("alarm", alarm, m_alarm);
    chk("locked", locked, m_locked);
    chk("window", window_active, m_win);
    chk("count", violation_count, m_count);
  endtask

  function automatic void model_violate();
    if (m_count < 255) m_count++;
    m_alarm = 1;
    if (m_count >= THRESH) m_locked = 1;
  endfunction

  function automatic void model_step(input logic [3:0] g, input bit s, input bit r, input bit c);
    bit ch;
    ch = (g != m_prev);
    cyc++;
    if (m_alarm) begin
      if (ch) model_violate();
      else if (c && !m_locked) m_alarm = 0;
    end else if (m_win) begin
      if (ch) m_led = g;
      if (r) m_win = 0;
      else if (s) deadline = cyc + W;
      else if (cyc == deadline) m_win = 0;
    end else begin
      if (ch) model_violate();
      else if (s) begin
        m_win = 1;
        deadline = cyc + W;
      end
    end
    m_prev = g;
  endfunction

  task automatic step(input logic [3:0] g, input bit s, input bit r, input bit c);
    @(negedge Clock);
    cpu_gpio = g; svc_entry = s; ret_exec = r; clear_alarm = c;
    model_step(g, s, r, c);
    @(posedge Clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge Clock);
    reset = 1'b1;
    cpu_gpio = 4'hF; svc_entry = 0; ret_exec = 0; clear_alarm = 0;
    #1;
    chk("rst_led", led_out, 4'hF);
    chk("rst_alarm", alarm, 0);
    chk("rst_locked", locked, 0);
    chk("rst_window", window_active, 0);
    chk("rst_count", violation_count, 0);
    @(posedge Clock);
    @(negedge Clock);
    reset = 1'b0;
    m_win = 0; m_alarm = 0; m_locked = 0; m_count = 0; m_led = 4'hF; m_prev = 4'hF;
  endtask

  initial begin
    logic [3:0] g;
    // Legal write
    do_reset();
    step(4'hF, 1, 0, 0);
    step(4'hF, 0, 0, 0);
    step(4'h1, 0, 0, 0);
    chk("legal_led", led_out, 4'h1);
    chk("legal_alarm", alarm, 0);
    // Illegal write and clear
    do_reset();
    step(4'h4, 0, 0, 0);
    chk("illegal_led", led_out, 4'hF);
    chk("illegal_count", violation_count, 1);
    step(4'h4, 0, 0, 1);
    chk("clear_alarm", alarm, 0);
    chk("clear_count", violation_count, 1);
    // Timeout edge
    do_reset();
    step(4'hF, 1, 0, 0);
    for (int i = 0; i < W - 1; i++) step(4'hF, 0, 0, 0);
    step(4'hE, 0, 0, 0);
    chk("edge_accept", led_out, 4'hE);
    step(4'hD, 0, 0, 0);
    chk("edge_block_led", led_out, 4'hE);
    chk("edge_block_alarm", alarm, 1);
    // RET closes window
    do_reset();
    step(4'hF, 1, 0, 0);
    step(4'hF, 0, 0, 0);
    step(4'hF, 0, 1, 0);
    chk("ret_closed", window_active, 0);
    step(4'h7, 0, 0, 0);
    chk("ret_count", violation_count, 1);
    // Lockout
    do_reset();
    g = 4'hF;
    for (int i = 0; i < THRESH; i++) begin
      g = g ^ 4'h1;
      step(g, 0, 0, 0);
      step(g, 0, 0, 1);
    end
    chk("lock_locked", locked, 1);
    chk("lock_alarm", alarm, 1);
    chk("lock_count", violation_count, THRESH);
    // Simultaneous SVC and change
    do_reset();
    step(4'h2, 1, 0, 0);
    chk("simul_alarm", alarm, 1);
    chk("simul_window", window_active, 0);
    step(4'h2, 0, 0, 0);
    chk("simul_window2", window_active, 0);
    // Random traffic
    do_reset();
    g = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) g = 4'($urandom_range(0, 15));
      step(m_prev == 4'hF && reset ? 4'hF : g, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_guard.md
# gpio_guard

Hardware output guard between the CPU's `gpio` port and the board LEDs. It forwards GPIO changes only while a supervisor-call window is open. A window opens on an SVC entry event and closes on RET or timeout. Any change outside a window is blocked, counted and latched as an alarm, so unprivileged or trojan-driven writes never reach the pins.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 8: window length in cycles after the `svc_entry` cycle; legal range 1..255.
- `LED_RESET`, default 4'b1111: reset value of `led_out` and of the internal GPIO shadow; equals the CPU's GPIO reset value.
- `COUNT_WIDTH`, default 8: width of `violation_count`.
- `LOCK_THRESHOLD`, default 4: violation count at which the alarm becomes permanent.

Ports:
- `Clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_gpio` in 4: CPU GPIO output, synchronous to `Clock`.
- `svc_entry` in 1: one-cycle pulse, CPU decodes SVC.
- `ret_exec` in 1: one-cycle pulse, CPU decodes RET.
- `clear_alarm` in 1: synchronous, debounced one-cycle clear request.
- `led_out` out 4: guarded GPIO to pins.
- `alarm` out 1: violation latched.
- `locked` out 1: alarm permanent until reset.
- `window_active` out 1: high while in WINDOW.
- `violation_count` out COUNT_WIDTH: saturating violation counter.

## Operation
- Shadow register `gpio_q` samples `cpu_gpio` every cycle.
- `change` = (`cpu_gpio` != `gpio_q`). Evaluation is combinational in the current cycle.
- States: IDLE, WINDOW, ALARM. Encoding is free.
- IDLE:
  - `change` -> violation; go to ALARM.
  - Otherwise `svc_entry` -> WINDOW, window counter loaded with WINDOW_CYCLES.
  - `change` and `svc_entry` in the same cycle: violation wins; the SVC is ignored.
- WINDOW:
  - `change` -> `led_out` <= `cpu_gpio`. Any number of changes is accepted.
  - Counter decrements each cycle.
  - `svc_entry` reloads the counter to WINDOW_CYCLES.
  - `ret_exec`, or counter == 1 with no `svc_entry`, -> IDLE next cycle. A change in that same cycle is still accepted.
- ALARM:
  - `led_out` is frozen; `svc_entry` and `ret_exec` are ignored.
  - Each further `change` is a violation.
  - `clear_alarm` with `locked`=0 -> IDLE, `alarm`=0.
  - `clear_alarm` with `locked`=1 is ignored.
- Violation effects:
  - `violation_count` += 1, saturating at all-ones.
  - `alarm` <= 1.
  - `locked` <= 1 when the new count >= LOCK_THRESHOLD.
  - `led_out` is unchanged.
- Only reset clears `violation_count` and `locked`.
- `change` and `clear_alarm` in the same cycle in ALARM: the violation is counted and the state stays ALARM.
- `window_active` = (state == WINDOW), registered.

## Timing
- Reset values: `led_out`=LED_RESET, `gpio_q`=LED_RESET, `alarm`=0, `locked`=0, `window_active`=0, `violation_count`=0, state IDLE.
- Reset mid-window or in ALARM aborts immediately; there is no deferred effect.
- Latencies, all from the edge where `cpu_gpio` is sampled:
  - legal change -> `led_out`: 1 cycle.
  - violating change -> `alarm` / `violation_count` / `locked`: 1 cycle.
- Window timing:
  - `svc_entry` in cycle t -> `window_active` high from cycle t+1.
  - Changes are accepted in cycles t+1 .. t+WINDOW_CYCLES.
  - `window_active` drops at t+WINDOW_CYCLES+1 absent reload or RET.
- `ret_exec` in cycle r (inside WINDOW) -> `window_active` low at r+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Legal write:** reset, pulse `svc_entry`, change `cpu_gpio` 1111->0001 two cycles later.
  - `led_out`=0001 one cycle after; `alarm`=0; count 0.
- **Illegal write:** in IDLE, change `cpu_gpio` to 0100.
  - `led_out` stays 1111; `alarm`=1 and count=1 next cycle.
  - `clear_alarm` -> IDLE, `alarm`=0, count stays 1.
- **Timeout edge**, WINDOW_CYCLES=8, `svc_entry` at t:
  - change at t+8 -> accepted.
  - change at t+9 -> violation, `led_out` unchanged.
- **RET closes window:** `svc_entry`, then `ret_exec` at t+2, change at t+3 -> violation, count=1.
- **Lockout:** four violations separated by `clear_alarm`.
  - `locked`=1 after the 4th; next `clear_alarm` ignored; `alarm` stays 1.
  - Reset clears everything to reset values.
- **Simultaneous events** in IDLE: `svc_entry` and change in the same cycle.
  - Violation counted; state ALARM; `window_active` stays 0.
